uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART serializer: accepts a parallel word on a single-cycle enable, then shifts out a full asynchronous frame (start bit, LSB-first data, optional parity, one or two stop bits) at a programmable bit period. It is the configurable successor to the team's fixed-format transmitter, with a baud divider, parity and stop-bit options, and a completion pulse. It sits between a byte or word producer (FIFO or CPU register) and the serial output pin.

## Interface
- DATA_W, 8, data bits per frame; legal 5..16.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal ≥1.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd; 3 is illegal.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tx_ena  in  1  request to send tx_data; sampled only when idle.
- tx_data  in  DATA_W  word to send; latched on accept.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is in flight.
- tx_done  out  1  one-cycle pulse when the last stop bit completes.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Reset (asynchronous, immediate): state IDLE, tx=1, tx_busy=0, tx_done=0, and all counters and the shift register cleared. A reset mid-frame abandons the frame with no tx_done.
- IDLE: tx=1, tx_busy=0. If tx_ena=1 at a rising edge, latch tx_data into the shift register and compute the parity bit:
  - even: XOR of the data bits;
  - odd: the inverted XOR.
  - Then go to START with tx=0 and tx_busy=1 from that edge.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: drive tx=shift[0]. After each CLKS_PER_BIT cycles, shift right. After DATA_W bits, go to PAR if PARITY≠0, else STOP.
- PAR: hold tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: hold tx=1 for STOP_BITS×CLKS_PER_BIT cycles. On the final edge:
  - go to IDLE;
  - set tx_busy=0;
  - set tx_done=1 for exactly one cycle.
- tx_ena while busy is ignored. tx_data changes while busy do not affect the frame in flight.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. Width is clog2(CLKS_PER_BIT), minimum 1. CLKS_PER_BIT=1 is legal and gives one bit per cycle.
- Bit counter: width clog2(DATA_W+1). It never overflows within legal parameters.
- tx is a registered output with no combinational path from any input.

## Timing
- Frame bits F = 1 + DATA_W + (PARITY≠0) + STOP_BITS.
- Accept edge = E0. tx_busy is high and tx carries frame bits during cycles E0..E0+F×CLKS_PER_BIT−1. Bit n occupies cycles E0+n×CLKS_PER_BIT .. E0+(n+1)×CLKS_PER_BIT−1.
- At edge E0+F×CLKS_PER_BIT: tx_busy falls and tx_done rises. tx stays 1.
- tx_done falls at the following edge unless a new frame ends there, which is impossible for F≥7.
- Back-to-back: tx_ena held high starts the next frame one edge after tx_done. The minimum line-idle gap between frames is therefore exactly 1 cycle beyond the stop bits.
- tx_ena=1 at the same edge tx_done asserts is not accepted (state not yet IDLE for sampling).
- Reset deasserted at an edge with tx_ena=1: the accept occurs at the first edge after reset is low.

## Test plan
- Defaults (8N1, CLKS_PER_BIT=4), send 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_busy high for 40 cycles; tx_done a single pulse at cycle 40.
- PARITY=1, send 0x07 → parity bit 1; PARITY=2, send 0x07 → parity bit 0; frame length 11 bits (44 cycles).
- STOP_BITS=2, CLKS_PER_BIT=1, DATA_W=5, send 0x1F → tx 0,1,1,1,1,1,1,1; tx_busy high for exactly 8 cycles.
- During a 0x3C frame, pulse tx_ena with tx_data=0xFF at cycle 10 → the serial frame is still 0x3C; no second frame; one tx_done.
- Assert rst asynchronously at cycle 17 of a frame (between edges) → tx=1 and tx_busy=0 immediately; no tx_done; the next accepted frame (0x81) is correct.
- tx_ena held high with 0x55 then 0xAA → two frames; tx_done pulses 41 cycles apart; exactly 1 extra idle-high cycle between frames.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// All outputs are registered; tx_done pulses for one cycle as the frame completes.
module uart_tx_frame #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_ena,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CntW   = $clog2(DATA_W + 1);

    localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]   LastData = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0]   LastStop = CntW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;

    assign bit_end = (timer_q == TimerMax);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_ena) begin
                    shift_d = tx_data;
                    par_d   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
                    state_d = StStart;
                    timer_d = '0;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (cnt_q == LastData) begin
                        cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = StPar;
                            tx_d    = par_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        // Drive the next bit now so tx lands on the bit boundary.
                        tx_d  = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StPar: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (cnt_q == LastStop) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame across several frame formats, exercised one
// instance at a time while the idle instances are checked for staying quiet.
module tb_uart_tx_frame;

    localparam int NI = 5;

    function automatic int cfg_dw(int g);
        case (g)
            3:       return 5;
            4:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_cpb(int g);
        case (g)
            3:       return 1;
            4:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int cfg_par(int g);
        case (g)
            1:       return 1;
            2:       return 2;
            4:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(int g);
        case (g)
            3:       return 2;
            4:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int frame_cycles(int g);
        return (1 + cfg_dw(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_stop(g)) * cfg_cpb(g);
    endfunction

    // Value on the line during frame bit n.
    function automatic logic frame_bit(int g, logic [15:0] d, int n);
        int   dw;
        logic p;
        dw = cfg_dw(g);
        p  = 1'b0;
        for (int i = 0; i < dw; i++) p = p ^ d[i];
        if (n == 0) return 1'b0;
        if (n <= dw) return d[n-1];
        if (cfg_par(g) != 0 && n == dw + 1) return (cfg_par(g) == 2) ? ~p : p;
        return 1'b1;
    endfunction

    function automatic logic [15:0] first_word(int g);
        case (g)
            0:       return 16'h00A5;
            1:       return 16'h0007;
            2:       return 16'h0007;
            3:       return 16'h001F;
            default: return 16'hBEEF;
        endcase
    endfunction

    typedef struct {
        int          inst;
        int          start;
        logic [15:0] data;
    } frame_t;

    logic          clk;
    logic [NI-1:0] rst;
    logic [NI-1:0] tx_ena;
    logic [15:0]   tx_data [NI];
    logic [NI-1:0] tx;
    logic [NI-1:0] tx_busy;
    logic [NI-1:0] tx_done;

    int     cyc;
    int     next_free;
    int     last_start;
    int     expect_frames;
    int     frames_seen;
    int     n_cmp;
    int     n_bad;
    frame_t q[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW = cfg_dw(g);
        uart_tx_frame #(
            .DATA_W      (DW),
            .CLKS_PER_BIT(cfg_cpb(g)),
            .PARITY      (cfg_par(g)),
            .STOP_BITS   (cfg_stop(g))
        ) u_dut (
            .clk    (clk),
            .rst    (rst[g]),
            .tx_ena (tx_ena[g]),
            .tx_data(tx_data[g][DW-1:0]),
            .tx     (tx[g]),
            .tx_busy(tx_busy[g]),
            .tx_done(tx_done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int g, logic [2:0] act, logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc=%0d tx/busy/done got %b expected %b",
                     name, g, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; the word is accepted at the first edge the DUT is idle.
    task automatic issue(int g, logic [15:0] d, bit hold);
        while (cyc + 1 < next_free) @(negedge clk);
        tx_data[g] = d;
        tx_ena[g]  = 1'b1;
        q.push_back('{inst: g, start: cyc + 1, data: d});
        last_start = cyc + 1;
        next_free  = cyc + 1 + frame_cycles(g) + 1;
        expect_frames++;
        @(negedge clk);
        if (!hold) tx_ena[g] = 1'b0;
    endtask

    task automatic finish_frame(int g, int gap);
        while (cyc + 1 < next_free) @(negedge clk);
        tx_ena[g] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic run_instance(int g);
        int fc;
        int st;
        int gap;
        fc = frame_cycles(g);

        issue(g, first_word(g), 1'b0);
        finish_frame(g, 2);

        // Request while busy must be ignored.
        issue(g, 16'h003C, 1'b0);
        st = last_start;
        while (cyc + 1 < st + ((fc > 12) ? 10 : 3)) @(negedge clk);
        tx_ena[g]  = 1'b1;
        tx_data[g] = 16'hFFFF;
        @(negedge clk);
        tx_ena[g]  = 1'b0;
        finish_frame(g, 1);

        // Asynchronous reset mid-frame, then a request held across reset release.
        issue(g, 16'h00C3, 1'b0);
        st = last_start;
        while (cyc + 1 < st + ((fc > 20) ? 17 : 5)) @(negedge clk);
        @(posedge clk);
        #1;
        rst[g] = 1'b1;
        #1;
        check("rst_async", g, {tx[g], tx_busy[g], tx_done[g]}, 3'b100);
        @(negedge clk);
        tx_data[g] = 16'h0081;
        tx_ena[g]  = 1'b1;
        @(negedge clk);
        rst[g] = 1'b0;
        expect_frames--;
        next_free = 0;
        issue(g, 16'h0081, 1'b0);
        finish_frame(g, 2);

        // Back-to-back with tx_ena held high.
        issue(g, 16'h0055, 1'b1);
        tx_data[g] = 16'h00AA;
        issue(g, 16'h00AA, 1'b0);
        finish_frame(g, 2);

        repeat (12) begin
            gap = $urandom_range(0, 3);
            issue(g, 16'($urandom), gap == 0);
            if (gap != 0) begin
                while (cyc + 1 < next_free) begin
                    tx_data[g] = 16'($urandom);
                    tx_ena[g]  = ($urandom_range(0, 3) == 0);
                    @(negedge clk);
                end
                tx_ena[g] = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        finish_frame(g, 3);
        next_free = 0;
    endtask

    // Monitor: checks every instance's line each cycle against the queued frames.
    initial begin
        frame_t     cur;
        bit         cur_valid;
        logic [2:0] e;
        int         k;
        cur_valid = 1'b0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (rst[g]) begin
                    if (cur_valid && cur.inst == g) cur_valid = 1'b0;
                    continue;
                end
                if (!cur_valid && q.size() != 0 && q[0].inst == g && q[0].start == cyc) begin
                    cur       = q.pop_front();
                    cur_valid = 1'b1;
                end
                e = 3'b100;
                if (cur_valid && cur.inst == g) begin
                    k = cyc - cur.start;
                    if (k < frame_cycles(g)) begin
                        e = {frame_bit(g, cur.data, k / cfg_cpb(g)), 2'b10};
                    end else begin
                        e         = 3'b101;
                        cur_valid = 1'b0;
                        frames_seen++;
                    end
                end
                check("line", g, {tx[g], tx_busy[g], tx_done[g]}, e);
            end
        end
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        next_free     = 0;
        last_start    = 0;
        expect_frames = 0;
        frames_seen   = 0;
        rst           = '1;
        tx_ena        = '0;
        for (int i = 0; i < NI; i++) tx_data[i] = '0;
        #2;
        for (int i = 0; i < NI; i++) check("reset", i, {tx[i], tx_busy[i], tx_done[i]}, 3'b100);
        @(negedge clk);
        @(negedge clk);
        rst = '0;
        @(negedge clk);

        for (int g = 0; g < NI; g++) run_instance(g);

        repeat (4) @(negedge clk);
        check_int("queue_drained", q.size(), 0);
        check_int("frames_completed", frames_seen, expect_frames);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
